// File: rtl/mmio_led_timer_responder.sv
// Data-memory bus target exposing an RGB/LED PWM duty register and free-running
// microsecond / millisecond counters at three fixed word addresses.
module mmio_led_timer_responder #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter logic [31:0] LEDS_ADDR   = 32'hFFFFFFFC,
    parameter logic [31:0] MILLIS_ADDR = 32'hFFFFFFF8,
    parameter logic [31:0] MICROS_ADDR = 32'hFFFFFFF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        dmem_hit,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int unsigned US_DIV  = CLK_FREQ_HZ / 1000000;
    localparam int          PRESC_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PRESC_W-1:0] US_LAST = PRESC_W'(US_DIV - 1);
    localparam logic [9:0]  MS_LAST = 10'd999;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0]        leds_q, leds_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [PRESC_W-1:0] us_presc_q, us_presc_d;
    logic [9:0]         ms_presc_q, ms_presc_d;
    logic [31:0]        micros_q, micros_d;
    logic [31:0]        millis_q, millis_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               hit_q, hit_d;
    logic [3:0]         pwm_q, pwm_d;

    logic        hit_leds, hit_millis, hit_micros;
    logic [1:0]  offset;
    logic [3:0]  lane_we;
    logic [31:0] wdata;
    logic [31:0] word_sel;
    logic [31:0] shifted;
    logic        us_tick;

    always_comb begin
        hit_leds   = (dmem_address[31:2] == LEDS_ADDR[31:2]);
        hit_millis = (dmem_address[31:2] == MILLIS_ADDR[31:2]);
        hit_micros = (dmem_address[31:2] == MICROS_ADDR[31:2]);
        offset     = dmem_address[1:0];
    end

    // Byte-lane enables; misaligned halves/words and unsupported sizes give no lanes.
    always_comb begin
        lane_we = 4'b0000;
        if (dmem_wren && hit_leds) begin
            case (funct3)
                F3_B: lane_we = 4'b0001 << offset;
                F3_H: if (!offset[0]) lane_we = offset[1] ? 4'b1100 : 4'b0011;
                F3_W: if (offset == 2'b00) lane_we = 4'b1111;
                default: lane_we = 4'b0000;
            endcase
        end
        wdata = dmem_data_in << {offset, 3'b000};
    end

    always_comb begin
        leds_d = leds_q;
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) leds_d[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // Load path reads the pre-edge register values, giving read-before-write.
    always_comb begin
        word_sel = 32'h0;
        if (hit_leds)        word_sel = leds_q;
        else if (hit_millis) word_sel = millis_q;
        else if (hit_micros) word_sel = micros_q;
        shifted = word_sel >> {offset, 3'b000};
        hit_d   = hit_leds | hit_millis | hit_micros;
        case (funct3)
            F3_B:    data_out_d = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_out_d = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_out_d = {24'h0, shifted[7:0]};
            F3_HU:   data_out_d = {16'h0, shifted[15:0]};
            default: data_out_d = shifted;
        endcase
        if (!hit_d) data_out_d = 32'h0;
    end

    always_comb begin
        us_tick    = (us_presc_q == US_LAST);
        us_presc_d = us_tick ? '0 : us_presc_q + 1'b1;
        micros_d   = micros_q + {31'h0, us_tick};
        ms_presc_d = ms_presc_q;
        millis_d   = millis_q;
        if (us_tick) begin
            if (ms_presc_q == MS_LAST) begin
                ms_presc_d = 10'd0;
                millis_d   = millis_q + 32'd1;
            end else begin
                ms_presc_d = ms_presc_q + 10'd1;
            end
        end
    end

    // Channel i takes its duty from byte lane i: blue, green, red, led.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = (pwm_cnt_q < leds_q[8*i +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q     <= 32'h0;
            pwm_cnt_q  <= 8'h0;
            us_presc_q <= '0;
            ms_presc_q <= 10'd0;
            micros_q   <= 32'h0;
            millis_q   <= 32'h0;
            data_out_q <= 32'h0;
            hit_q      <= 1'b0;
            pwm_q      <= 4'b0000;
        end else begin
            leds_q     <= leds_d;
            pwm_cnt_q  <= pwm_cnt_d;
            us_presc_q <= us_presc_d;
            ms_presc_q <= ms_presc_d;
            micros_q   <= micros_d;
            millis_q   <= millis_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
            pwm_q      <= pwm_d;
        end
    end

    assign dmem_data_out = data_out_q;
    assign dmem_hit      = hit_q;
    assign blue          = pwm_q[0];
    assign green         = pwm_q[1];
    assign red           = pwm_q[2];
    assign led           = pwm_q[3];

endmodule

// File: tb/tb_mmio_led_timer_responder.sv
// Bench for mmio_led_timer_responder: directed scenarios plus randomized
// accesses checked against a byte-array / cycle-count reference model.
module tb_mmio_led_timer_responder;

    localparam int unsigned CLK_HZ = 12000000;
    localparam int unsigned DIV    = CLK_HZ / 1000000;
    localparam logic [31:0] A_LEDS   = 32'hFFFFFFFC;
    localparam logic [31:0] A_MILLIS = 32'hFFFFFFF8;
    localparam logic [31:0] A_MICROS = 32'hFFFFFFF4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  funct3 = 3'b010;
    logic        dmem_wren = 1'b0;
    logic [31:0] dmem_address = 32'h0;
    logic [31:0] dmem_data_in = 32'h0;
    logic [31:0] dmem_data_out;
    logic        dmem_hit;
    logic        led, red, green, blue;

    int checks = 0;
    int errors = 0;
    longint unsigned k = 0;
    logic [7:0] m_leds [4];

    mmio_led_timer_responder #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_out(dmem_data_out), .dmem_hit(dmem_hit),
        .led(led), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset edge: the timers are pure functions of it.
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    function automatic logic [31:0] m_word();
        return {m_leds[3], m_leds[2], m_leds[1], m_leds[0]};
    endfunction

    function automatic logic [32:0] exp_load(input logic [31:0] addr, input logic [2:0] f3,
                                             input longint unsigned kk);
        logic [31:0] w;
        logic [31:0] s;
        logic        h;
        h = 1'b1;
        if (addr[31:2] == A_LEDS[31:2])        w = m_word();
        else if (addr[31:2] == A_MILLIS[31:2]) w = 32'(kk / (DIV * 1000));
        else if (addr[31:2] == A_MICROS[31:2]) w = 32'(kk / DIV);
        else begin h = 1'b0; w = 32'h0; end
        s = w >> (8 * addr[1:0]);
        case (f3)
            3'b000: s = {{24{s[7]}}, s[7:0]};
            3'b001: s = {{16{s[15]}}, s[15:0]};
            3'b100: s = {24'h0, s[7:0]};
            3'b101: s = {16'h0, s[15:0]};
            default: ;
        endcase
        if (!h) s = 32'h0;
        return {h, s};
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
        int off;
        off = int'(addr[1:0]);
        if (addr[31:2] != A_LEDS[31:2]) return;
        case (f3)
            3'b000: m_leds[off] = d[7:0];
            3'b001: if (off % 2 == 0) begin m_leds[off] = d[7:0]; m_leds[off+1] = d[15:8]; end
            3'b010: if (off == 0) begin
                m_leds[0] = d[7:0]; m_leds[1] = d[15:8]; m_leds[2] = d[23:16]; m_leds[3] = d[31:24];
            end
            default: ;
        endcase
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m_leds[i] = 8'h0;
    endtask

    // Drives one access at a falling edge and returns what the DUT shows one cycle later.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] d, output logic [32:0] expv,
                          output logic hit_o, output logic [31:0] data_o);
        dmem_wren = wr; dmem_address = addr; funct3 = f3; dmem_data_in = d;
        expv = exp_load(addr, f3, k);
        if (wr) m_store(addr, f3, d);
        @(negedge clk);
        dmem_wren = 1'b0;
        hit_o = dmem_hit; data_o = dmem_data_out;
        $display("txn wr=%0d addr=%h f3=%0d din=%h -> hit=%0d dout=%h exp_hit=%0d exp_dout=%h",
                 wr, addr, f3, d, hit_o, data_o, expv[32], expv[31:0]);
    endtask

    task automatic count_pwm(output int cl, output int cr, output int cg, output int cb);
        cl = 0; cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cl += int'(led); cr += int'(red); cg += int'(green); cb += int'(blue);
        end
        $display("txn pwm window: led=%0d red=%0d green=%0d blue=%0d", cl, cr, cg, cb);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dmem_wren = 1'b1; dmem_address = A_LEDS; funct3 = 3'b010; dmem_data_in = 32'hA5A5A5A5;
        repeat (3) @(negedge clk);
        checks++;
        if ({dmem_hit, dmem_data_out, led, red, green, blue} !== 37'h0) begin
            errors++;
            $display("FAIL reset_outputs: got hit=%0d dout=%h pwm=%b%b%b%b, want all 0",
                     dmem_hit, dmem_data_out, led, red, green, blue);
        end
        dmem_wren = 1'b0; reset = 1'b0;
        clear_model();
        begin
            logic [32:0] e; logic h; logic [31:0] d;
            access(1'b0, A_LEDS, 3'b010, 32'h0, e, h, d);
            checks++;
            if ({h, d} !== 33'h1_0000_0000) begin
                errors++;
                $display("FAIL reset_leds: got hit=%0d dout=%h, want hit=1 dout=00000000", h, d);
            end
        end
    endtask

    task automatic test_sw_leds();
        logic [32:0] e; logic h; logic [31:0] d;
        int cl, cr, cg, cb;
        access(1'b1, A_LEDS, 3'b010, 32'hFFFF0000, e, h, d);
        access(1'b0, A_LEDS, 3'b010, 32'h0, e, h, d);
        checks++;
        if (h !== 1'b1 || d !== 32'hFFFF0000) begin
            errors++;
            $display("FAIL sw_lw: got hit=%0d dout=%h, want hit=1 dout=ffff0000", h, d);
        end
        @(negedge clk);
        count_pwm(cl, cr, cg, cb);
        checks++;
        if (cl != 255 || cr != 255 || cg != 0 || cb != 0) begin
            errors++;
            $display("FAIL sw_pwm: got %0d/%0d/%0d/%0d, want 255/255/0/0", cl, cr, cg, cb);
        end
    endtask

    task automatic test_sb_lanes();
        logic [32:0] e; logic h; logic [31:0] d;
        int cl, cr, cg, cb;
        access(1'b1, 32'hFFFFFFFD, 3'b000, 32'h00000080, e, h, d);
        access(1'b0, 32'hFFFFFFFD, 3'b000, 32'h0, e, h, d);
        checks++;
        if (d !== 32'hFFFFFF80 || d !== e[31:0]) begin
            errors++;
            $display("FAIL sb_lb: got %h, want ffffff80", d);
        end
        access(1'b0, 32'hFFFFFFFD, 3'b100, 32'h0, e, h, d);
        checks++;
        if (d !== 32'h00000080 || d !== e[31:0]) begin
            errors++;
            $display("FAIL sb_lbu: got %h, want 00000080", d);
        end
        @(negedge clk);
        count_pwm(cl, cr, cg, cb);
        checks++;
        if (cg != 128 || cl != 255 || cr != 255 || cb != 0) begin
            errors++;
            $display("FAIL sb_pwm: got %0d/%0d/%0d/%0d, want 255/255/128/0", cl, cr, cg, cb);
        end
    endtask

    task automatic test_misaligned();
        logic [32:0] e; logic h; logic [31:0] d;
        access(1'b1, 32'hFFFFFFFD, 3'b001, 32'h0000BEEF, e, h, d);
        checks++;
        if ({h, d} !== e) begin
            errors++;
            $display("FAIL misaligned_sh_rbw: got %h, want %h", d, e[31:0]);
        end
        access(1'b1, A_MILLIS, 3'b010, 32'hDEADBEEF, e, h, d);
        checks++;
        if ({h, d} !== e) begin
            errors++;
            $display("FAIL store_millis_rbw: got hit=%0d %h, want hit=%0d %h", h, d, e[32], e[31:0]);
        end
        access(1'b0, A_LEDS, 3'b010, 32'h0, e, h, d);
        checks++;
        if (d !== 32'hFFFF8000 || {h, d} !== e) begin
            errors++;
            $display("FAIL misaligned_leds: got %h, want ffff8000", d);
        end
        access(1'b0, A_MILLIS, 3'b010, 32'h0, e, h, d);
        checks++;
        if ({h, d} !== e) begin
            errors++;
            $display("FAIL millis_untouched: got %h, want %h", d, e[31:0]);
        end
    endtask

    task automatic test_random();
        logic [32:0] e; logic h; logic [31:0] d;
        logic [31:0] addr;
        logic [2:0]  f3s [5];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0, 1: addr = A_LEDS;
                2:    addr = A_MILLIS;
                3:    addr = A_MICROS;
                default: begin addr = $urandom(); addr[31:28] = 4'h0; end
            endcase
            addr[1:0] = 2'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), addr, f3s[$urandom_range(0, 4)], $urandom(), e, h, d);
            checks++;
            if ({h, d} !== e) begin
                errors++;
                $display("FAIL random_access %0d: got hit=%0d %h, want hit=%0d %h", i, h, d, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_timers_12000();
        logic [32:0] e; logic h; logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        while (k < 12000) @(negedge clk);
        access(1'b0, A_MICROS, 3'b010, 32'h0, e, h, d);
        checks++;
        if (h !== 1'b1 || d !== 32'd1000) begin
            errors++;
            $display("FAIL micros_12000: got hit=%0d %0d, want 1000", h, d);
        end
        access(1'b0, A_MILLIS, 3'b010, 32'h0, e, h, d);
        checks++;
        if (h !== 1'b1 || d !== 32'd1) begin
            errors++;
            $display("FAIL millis_12000: got hit=%0d %0d, want 1", h, d);
        end
        access(1'b0, 32'h00001000, 3'b010, 32'h0, e, h, d);
        checks++;
        if (h !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_load: got hit=%0d %h, want hit=0 00000000", h, d);
        end
    endtask

    task automatic test_micros_wrap();
        logic [31:0] v;
        bit seen_zero;
        bit bad;
        seen_zero = 0; bad = 0;
        force dut.micros_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.micros_q;
        dmem_wren = 1'b0; dmem_address = A_MICROS; funct3 = 3'b010;
        for (int i = 0; i < 2 * DIV + 2 && !seen_zero; i++) begin
            @(negedge clk);
            v = dmem_data_out;
            if (v == 32'h0) seen_zero = 1;
            else if (v != 32'hFFFFFFFF) bad = 1;
        end
        $display("txn micros wrap: last=%h seen_zero=%0d", v, seen_zero);
        checks++;
        if (!seen_zero || bad) begin
            errors++;
            $display("FAIL micros_wrap: got last=%h other_value=%0d, want ffffffff then 00000000", v, bad);
        end
    endtask

    task automatic test_reset_mid_period();
        logic [32:0] e; logic h; logic [31:0] d;
        access(1'b1, A_LEDS, 3'b010, 32'hFFFFFFFF, e, h, d);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        dmem_wren = 1'b1; dmem_address = A_LEDS; funct3 = 3'b010; dmem_data_in = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({dmem_hit, dmem_data_out, led, red, green, blue} !== 37'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got hit=%0d dout=%h pwm=%b%b%b%b, want all 0",
                     dmem_hit, dmem_data_out, led, red, green, blue);
        end
        reset = 1'b0; dmem_wren = 1'b0;
        clear_model();
        access(1'b0, A_LEDS, 3'b010, 32'h0, e, h, d);
        checks++;
        if (d !== 32'h0 || {h, d} !== e) begin
            errors++;
            $display("FAIL midreset_store_lost: got %h, want 00000000", d);
        end
        access(1'b0, A_MICROS, 3'b010, 32'h0, e, h, d);
        checks++;
        if ({h, d} !== e) begin
            errors++;
            $display("FAIL midreset_micros: got %h, want %h", d, e[31:0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({led, red, green, blue} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_pwm: got %b%b%b%b, want 0000", led, red, green, blue);
        end
    endtask

    initial begin
        clear_model();
        @(negedge clk);
        test_reset();
        test_sw_leds();
        test_sb_lanes();
        test_misaligned();
        test_random();
        test_timers_12000();
        test_micros_wrap();
        test_reset_mid_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
